// File: rtl/multicycle_core_if.sv
// Instruction fetch, writeback and status bundle for multicycle_core.
// The master side is the core; the slave side is ROM plus observer.
interface multicycle_core_if #(
    parameter int DW = 8,
    parameter int PW = 8
);
    logic          en;
    logic [PW-1:0] imem_addr;
    logic [15:0]   imem_data;
    logic          wb_en;
    logic [2:0]    wb_addr;
    logic [DW-1:0] wb_data;
    logic          halted;

    modport master (
        input  en,
        input  imem_data,
        output imem_addr,
        output wb_en,
        output wb_addr,
        output wb_data,
        output halted
    );

    modport slave (
        output en,
        output imem_data,
        input  imem_addr,
        input  wb_en,
        input  wb_addr,
        input  wb_data,
        input  halted
    );
endinterface

// File: rtl/multicycle_core.sv
// Multi-cycle register CPU core: FETCH/DECODE/EXEC/WRITE/BRANCH/HALT.
// 16-bit instructions, 8 x DW register file, run-enable freeze.
module multicycle_core #(
    parameter int DW = 8,
    parameter int PW = 8
) (
    input  logic               clk,
    input  logic               rst,
    multicycle_core_if.master  bus
);
    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WRITE,
        S_BRANCH,
        S_HALT
    } state_t;

    localparam logic [2:0] OP_MUL  = 3'b000;
    localparam logic [2:0] OP_XNOR = 3'b001;
    localparam logic [2:0] OP_MOV  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_LDI  = 3'b100;
    localparam logic [2:0] OP_BNZ  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    state_t        state;
    logic [PW-1:0] pc;
    logic [15:0]   ir;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] result;
    logic [DW-1:0] regs [8];
    logic          halted_q;

    logic [2:0]    op;
    logic [2:0]    rd;
    logic [2:0]    rs1;
    logic [2:0]    rs2;
    logic [7:0]    imm;
    logic [DW-1:0] alu;

    assign op  = ir[15:13];
    assign rd  = ir[12:10];
    assign rs1 = ir[9:7];
    assign rs2 = ir[6:4];
    assign imm = ir[7:0];

    always_comb begin
        alu = '0;
        unique case (op)
            OP_MUL:  alu = a * b;
            OP_XNOR: alu = ~(a ^ b);
            OP_MOV:  alu = b;
            OP_ADD:  alu = a + b;
            OP_SUB:  alu = a - b;
            default: alu = '0;
        endcase
    end

    // A write only retires while enabled, so the pulse follows en.
    assign bus.wb_en     = (state == S_WRITE) && bus.en;
    assign bus.wb_addr   = rd;
    assign bus.wb_data   = result;
    assign bus.imem_addr = pc;
    assign bus.halted    = halted_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_FETCH;
            pc       <= '0;
            ir       <= '0;
            a        <= '0;
            b        <= '0;
            result   <= '0;
            halted_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.en) begin
            unique case (state)
                S_FETCH: begin
                    ir    <= bus.imem_data;
                    pc    <= pc + 1'b1;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    a <= (op == OP_BNZ) ? regs[rd] : regs[rs1];
                    b <= regs[rs2];
                    unique case (op)
                        OP_LDI: begin
                            result <= DW'(imm);
                            state  <= S_WRITE;
                        end
                        OP_BNZ:  state <= S_BRANCH;
                        OP_HALT: begin
                            halted_q <= 1'b1;
                            state    <= S_HALT;
                        end
                        default: state <= S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    result <= alu;
                    state  <= S_WRITE;
                end
                S_WRITE: begin
                    regs[rd] <= result;
                    state    <= S_FETCH;
                end
                S_BRANCH: begin
                    if (a != '0) begin
                        pc <= imm[PW-1:0];
                    end
                    state <= S_FETCH;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: three instances cover the
// default widths, a 2-bit PC and a 16-bit datapath.
module tb_multicycle_core;
    logic clk;
    logic rst_a;
    logic rst_w;
    logic rst_x;

    int checks;
    int errors;
    int cur;

    logic [15:0] rom_a [256];
    logic [15:0] rom_w [4];
    logic [15:0] rom_x [256];

    multicycle_core_if #(.DW(8),  .PW(8)) bus_a ();
    multicycle_core_if #(.DW(8),  .PW(2)) bus_w ();
    multicycle_core_if #(.DW(16), .PW(8)) bus_x ();

    multicycle_core #(.DW(8), .PW(8)) u_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );
    multicycle_core #(.DW(8), .PW(2)) u_w (
        .clk (clk),
        .rst (rst_w),
        .bus (bus_w)
    );
    multicycle_core #(.DW(16), .PW(8)) u_x (
        .clk (clk),
        .rst (rst_x),
        .bus (bus_x)
    );

    assign bus_a.imem_data = rom_a[bus_a.imem_addr];
    assign bus_w.imem_data = rom_w[bus_w.imem_addr];
    assign bus_x.imem_data = rom_x[bus_x.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed signals of the instance under test.
    logic        m_wb;
    logic        m_halt;
    logic [2:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] m_pc;

    always_comb begin
        m_wb   = bus_a.wb_en;
        m_halt = bus_a.halted;
        m_addr = bus_a.wb_addr;
        m_data = 32'(bus_a.wb_data);
        m_pc   = 32'(bus_a.imem_addr);
        if (cur == 1) begin
            m_wb   = bus_w.wb_en;
            m_halt = bus_w.halted;
            m_addr = bus_w.wb_addr;
            m_data = 32'(bus_w.wb_data);
            m_pc   = 32'(bus_w.imem_addr);
        end else if (cur == 2) begin
            m_wb   = bus_x.wb_en;
            m_halt = bus_x.halted;
            m_addr = bus_x.wb_addr;
            m_data = 32'(bus_x.wb_data);
            m_pc   = 32'(bus_x.imem_addr);
        end
    end

    function automatic logic [15:0] rr(input logic [2:0] op,
                                       input logic [2:0] rd,
                                       input logic [2:0] rs1,
                                       input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 4'b0000};
    endfunction

    function automatic logic [15:0] li(input logic [2:0] rd,
                                       input logic [7:0] imm);
        return {3'b100, rd, 2'b00, imm};
    endfunction

    function automatic logic [15:0] bnz(input logic [2:0] rd,
                                        input logic [7:0] tgt);
        return {3'b101, rd, 2'b00, tgt};
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the next writeback pulse and check it.
    task automatic expect_wb(input string tag,
                             input logic [2:0] ea,
                             input logic [31:0] ed,
                             input int ecyc,
                             input logic [31:0] epc);
        int cyc;
        cyc = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (m_wb) begin
                cyc = i;
                break;
            end
        end
        chk({tag, " latency"}, 32'(cyc), 32'(ecyc));
        chk({tag, " wb_addr"}, 32'(m_addr), 32'(ea));
        chk({tag, " wb_data"}, m_data, ed);
        chk({tag, " imem_addr"}, m_pc, epc);
    endtask

    initial begin
        logic saw;
        checks = 0;
        errors = 0;
        cur    = 0;
        rst_a  = 1'b1;
        rst_w  = 1'b1;
        rst_x  = 1'b1;
        bus_a.en = 1'b1;
        bus_w.en = 1'b1;
        bus_x.en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            rom_a[i] = 16'hE000;
            rom_x[i] = 16'hE000;
        end
        for (int i = 0; i < 4; i++) begin
            rom_w[i] = 16'hE000;
        end

        // Program A: ALU ops, countdown loop, halt.
        rom_a[0]  = 16'h8405;
        rom_a[1]  = li(3'd1, 8'h10);
        rom_a[2]  = li(3'd2, 8'h11);
        rom_a[3]  = 16'h0CA0;
        rom_a[4]  = rr(3'b001, 3'd4, 3'd1, 3'd1);
        rom_a[5]  = li(3'd5, 8'h01);
        rom_a[6]  = rr(3'b011, 3'd6, 3'd4, 3'd5);
        rom_a[7]  = rr(3'b110, 3'd7, 3'd6, 3'd5);
        rom_a[8]  = rr(3'b010, 3'd0, 3'd3, 3'd7);
        rom_a[9]  = li(3'd1, 8'h03);
        rom_a[10] = li(3'd2, 8'h01);
        rom_a[11] = rr(3'b110, 3'd1, 3'd1, 3'd2);
        rom_a[12] = bnz(3'd1, 8'd11);
        rom_a[13] = 16'hE000;

        @(negedge clk);
        @(negedge clk);
        chk("rst wb_en", 32'(m_wb), 32'd0);
        chk("rst wb_addr", 32'(m_addr), 32'd0);
        chk("rst wb_data", m_data, 32'd0);
        chk("rst halted", 32'(m_halt), 32'd0);
        chk("rst imem_addr", m_pc, 32'd0);
        rst_a = 1'b0;

        expect_wb("ldi r1 05", 3'd1, 32'h05, 2, 32'd1);
        @(negedge clk);
        chk("wb pulse width", 32'(m_wb), 32'd0);
        expect_wb("ldi r1 10", 3'd1, 32'h10, 2, 32'd2);
        expect_wb("ldi r2 11", 3'd2, 32'h11, 3, 32'd3);
        expect_wb("mul", 3'd3, 32'h10, 4, 32'd4);
        expect_wb("xnor", 3'd4, 32'hFF, 4, 32'd5);
        expect_wb("ldi r5 01", 3'd5, 32'h01, 3, 32'd6);
        expect_wb("add wrap", 3'd6, 32'h00, 4, 32'd7);
        expect_wb("sub wrap", 3'd7, 32'hFF, 4, 32'd8);
        expect_wb("mov r0", 3'd0, 32'hFF, 4, 32'd9);
        expect_wb("loop ldi 3", 3'd1, 32'h03, 3, 32'd10);
        expect_wb("loop ldi r2", 3'd2, 32'h01, 3, 32'd11);
        expect_wb("loop sub 2", 3'd1, 32'h02, 4, 32'd12);
        expect_wb("loop sub 1", 3'd1, 32'h01, 7, 32'd12);
        expect_wb("loop sub 0", 3'd1, 32'h00, 7, 32'd12);
        repeat (5) @(negedge clk);
        chk("halt not yet", 32'(m_halt), 32'd0);
        @(negedge clk);
        chk("halted set", 32'(m_halt), 32'd1);
        chk("halt pc", m_pc, 32'd14);
        saw = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (m_pc != 32'd14 || m_wb || !m_halt) saw = 1'b1;
        end
        chk("halt frozen", 32'(saw), 32'd0);

        // Program B: freeze during EXEC, then async reset mid-EXEC.
        rst_a = 1'b1;
        rom_a[0] = li(3'd1, 8'h07);
        rom_a[1] = li(3'd2, 8'h02);
        rom_a[2] = rr(3'b011, 3'd3, 3'd1, 3'd2);
        rom_a[3] = rr(3'b110, 3'd4, 3'd1, 3'd2);
        rom_a[4] = 16'hE000;
        @(negedge clk);
        chk("rst clears halted", 32'(m_halt), 32'd0);
        rst_a = 1'b0;
        expect_wb("b ldi r1", 3'd1, 32'h07, 2, 32'd1);
        expect_wb("b ldi r2", 3'd2, 32'h02, 3, 32'd2);
        repeat (3) @(negedge clk);
        chk("exec pc", m_pc, 32'd3);
        bus_a.en = 1'b0;
        saw = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (m_pc != 32'd3 || m_wb) saw = 1'b1;
        end
        chk("freeze holds", 32'(saw), 32'd0);
        bus_a.en = 1'b1;
        @(negedge clk);
        chk("resume wb_en", 32'(m_wb), 32'd1);
        chk("resume wb_addr", 32'(m_addr), 32'd3);
        chk("resume wb_data", m_data, 32'h09);
        @(negedge clk);
        chk("resume single", 32'(m_wb), 32'd0);
        repeat (2) @(negedge clk);
        chk("sub exec pc", m_pc, 32'd4);
        #2 rst_a = 1'b1;
        #1;
        chk("async imem_addr", m_pc, 32'd0);
        chk("async wb_data", m_data, 32'd0);
        chk("async wb_addr", 32'(m_addr), 32'd0);
        chk("async wb_en", 32'(m_wb), 32'd0);
        saw = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (m_wb) saw = 1'b1;
        end
        chk("no wb in reset", 32'(saw), 32'd0);
        rst_a = 1'b0;
        expect_wb("restart", 3'd1, 32'h07, 2, 32'd1);

        // PW=2: pc wraps 3 -> 0.
        cur = 1;
        rom_w[0] = li(3'd1, 8'h01);
        rom_w[1] = li(3'd2, 8'h02);
        rom_w[2] = li(3'd3, 8'h03);
        rom_w[3] = li(3'd4, 8'h04);
        @(negedge clk);
        chk("w rst pc", m_pc, 32'd0);
        rst_w = 1'b0;
        expect_wb("w a0", 3'd1, 32'h01, 2, 32'd1);
        expect_wb("w a1", 3'd2, 32'h02, 3, 32'd2);
        expect_wb("w a2", 3'd3, 32'h03, 3, 32'd3);
        expect_wb("w a3", 3'd4, 32'h04, 3, 32'd0);
        expect_wb("w wrap", 3'd1, 32'h01, 3, 32'd1);

        // DW=16: no truncation of the sum.
        cur = 2;
        rom_x[0] = li(3'd1, 8'hFF);
        rom_x[1] = rr(3'b011, 3'd2, 3'd1, 3'd1);
        rom_x[2] = 16'hE000;
        @(negedge clk);
        rst_x = 1'b0;
        expect_wb("x ldi", 3'd1, 32'h00FF, 2, 32'd1);
        expect_wb("x add16", 3'd2, 32'h01FE, 4, 32'd2);
        repeat (3) @(negedge clk);
        chk("x halted", 32'(m_halt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
